// File: rtl/f_d_reg.sv
// Fetch-to-decode pipeline register: captures F-stage instruction/PC, honours
// stall and flush, and presents flop-driven D-stage fields plus a stall counter.
module f_d_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] F_instr,
  input  logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic [5:0]  D_opcode,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [4:0]  D_rd,
  output logic [5:0]  D_funct,
  output logic [15:0] D_imm16,
  output logic        D_extOp,
  output logic        D_valid,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        extOp;
    logic        valid;
  } dReg_t;

  localparam dReg_t BUBBLE = '{instr: 32'h0, pc: PC_RESET, pc8: PC_RESET + 32'd8,
                               extOp: 1'b0, valid: 1'b0};

  dReg_t dReg;
  logic  fExtOp;

  // andi/ori/xori/lui (6'h0C..6'h0F) zero-extend; everything else sign-extends.
  assign fExtOp = (F_instr[31:28] == 4'b0011) ? 1'b0 : 1'b1;

  // pc8 is registered alongside pc so the link value is flop-driven too.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dReg      <= BUBBLE;
      stall_cnt <= 16'h0;
    end else if (flush) begin
      dReg      <= BUBBLE;
    end else if (!en) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end else begin
      dReg.instr <= F_instr;
      dReg.pc    <= F_pc;
      dReg.pc8   <= F_pc + 32'd8;
      dReg.extOp <= fExtOp;
      dReg.valid <= 1'b1;
    end
  end

  assign D_instr  = dReg.instr;
  assign D_pc     = dReg.pc;
  assign D_pc8    = dReg.pc8;
  assign D_extOp  = dReg.extOp;
  assign D_valid  = dReg.valid;
  assign D_opcode = dReg.instr[31:26];
  assign D_rs     = dReg.instr[25:21];
  assign D_rt     = dReg.instr[20:16];
  assign D_rd     = dReg.instr[15:11];
  assign D_funct  = dReg.instr[5:0];
  assign D_imm16  = dReg.instr[15:0];

endmodule

// File: tb/tb_f_d_reg.sv
// Scoreboard bench for f_d_reg: each driven cycle pushes the expected D state,
// which is popped and compared one edge later.
module tb_f_d_reg;
  logic        clk = 1'b0;
  logic        reset_n, en, flush;
  logic [31:0] F_instr, F_pc;
  logic [31:0] D_instr, D_pc, D_pc8;
  logic [5:0]  D_opcode, D_funct;
  logic [4:0]  D_rs, D_rt, D_rd;
  logic [15:0] D_imm16, stall_cnt;
  logic        D_extOp, D_valid;

  always #5 clk = ~clk;

  f_d_reg dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .F_instr(F_instr), .F_pc(F_pc),
    .D_instr(D_instr), .D_pc(D_pc), .D_pc8(D_pc8), .D_opcode(D_opcode),
    .D_rs(D_rs), .D_rt(D_rt), .D_rd(D_rd), .D_funct(D_funct),
    .D_imm16(D_imm16), .D_extOp(D_extOp), .D_valid(D_valid), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        extOp;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbQ[$];
  int          nCmp = 0, nErr = 0;
  logic [31:0] mInstr = 32'h0, mPc = 32'h0000_3000;
  logic        mExt = 1'b0, mValid = 1'b0;
  logic [15:0] mCnt = 16'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic refExt(input logic [5:0] op);
    case (op)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: refExt = 1'b0;
      default:                    refExt = 1'b1;
    endcase
  endfunction

  task automatic step(input logic rn, input logic e, input logic f,
                      input logic [31:0] ins, input logic [31:0] pc);
    exp_t x;
    reset_n = rn; en = e; flush = f; F_instr = ins; F_pc = pc;
    if (!rn) begin
      mInstr = 32'h0; mPc = 32'h0000_3000; mExt = 1'b0; mValid = 1'b0; mCnt = 16'h0;
    end else if (f) begin
      mInstr = 32'h0; mPc = 32'h0000_3000; mExt = 1'b0; mValid = 1'b0;
    end else if (!e) begin
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end else begin
      mInstr = ins; mPc = pc; mExt = refExt(ins[31:26]); mValid = 1'b1;
    end
    x.instr = mInstr; x.pc = mPc; x.extOp = mExt; x.valid = mValid; x.cnt = mCnt;
    sbQ.push_back(x);
    @(posedge clk); #1;
    x = sbQ.pop_front();
    chk("instr",  D_instr,  x.instr);
    chk("pc",     D_pc,     x.pc);
    chk("pc8",    D_pc8,    x.pc + 32'd8);
    chk("opcode", {26'h0, D_opcode}, {26'h0, x.instr[31:26]});
    chk("rs",     {27'h0, D_rs},     {27'h0, x.instr[25:21]});
    chk("rt",     {27'h0, D_rt},     {27'h0, x.instr[20:16]});
    chk("rd",     {27'h0, D_rd},     {27'h0, x.instr[15:11]});
    chk("funct",  {26'h0, D_funct},  {26'h0, x.instr[5:0]});
    chk("imm16",  {16'h0, D_imm16},  {16'h0, x.instr[15:0]});
    chk("extOp",  {31'h0, D_extOp},  {31'h0, x.extOp});
    chk("valid",  {31'h0, D_valid},  {31'h0, x.valid});
    chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, x.cnt});
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; flush = 1'b0; F_instr = 32'h0; F_pc = 32'h0;
    #1;
    step(0, 1, 0, 32'hDEAD_BEEF, 32'h1234);
    step(0, 0, 1, 32'hDEAD_BEEF, 32'h1234);
    chk("rst_pc8_const", D_pc8, 32'h0000_3008);
    chk("rst_pc_const",  D_pc,  32'h0000_3000);

    step(1, 1, 0, 32'h3408_8001, 32'h0000_3000);   // ori
    chk("ori_imm_const", {16'h0, D_imm16}, 32'h0000_8001);
    chk("ori_ext_const", {31'h0, D_extOp}, 32'h0);
    chk("ori_rt_const",  {27'h0, D_rt},    32'd8);
    step(1, 1, 0, 32'h8FA9_FFFC, 32'h0000_3004);   // lw
    chk("lw_ext_const", {31'h0, D_extOp}, 32'h1);
    chk("lw_rs_const",  {27'h0, D_rs},    32'd29);

    step(1, 1, 0, 32'h1109_0003, 32'h0000_3004);   // beq then 3-cycle stall
    step(1, 0, 0, 32'h2010_0001, 32'h0000_3008);
    step(1, 0, 0, 32'h2010_0002, 32'h0000_3008);
    step(1, 0, 0, 32'h2010_0003, 32'h0000_3008);
    chk("stall_beq_const", D_instr, 32'h1109_0003);
    chk("stall_cnt_const", {16'h0, stall_cnt}, 32'd3);
    step(1, 1, 0, 32'h2010_0004, 32'h0000_3008);
    chk("resume_const", D_instr, 32'h2010_0004);

    step(1, 0, 1, 32'h2222_2222, 32'h0000_300C);   // flush + stall
    chk("flush_cnt_const", {16'h0, stall_cnt}, 32'd3);

    step(1, 1, 0, 32'h3C01_1234, 32'hFFFF_FFFC);   // lui at wrap PC
    chk("wrap_pc8_const", D_pc8, 32'h0000_0004);
    chk("lui_ext_const", {31'h0, D_extOp}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins, pc;
      ins = $urandom; pc = $urandom;
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ins, pc);
    end

    step(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("sat_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);
    mCnt = 16'hFFFF;
    step(1, 0, 0, 32'h1, 32'h2);
    step(0, 0, 0, 32'h1, 32'h2);
    chk("sat_rst_cnt", {16'h0, stall_cnt}, 32'h0);

    if (sbQ.size() != 0) chk("sb_empty", sbQ.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/f_d_reg.md
# f_d_reg

Fetch-to-decode pipeline register for the five-stage MIPS core. Captures the fetched instruction and its PC each cycle, honours stall and flush from the hazard unit, and presents pre-split instruction fields to the D stage, including the 16-bit immediate and the registered extension-mode select consumed directly by the D-stage immediate extender. All D-stage outputs come straight from flops.

## Interface
- PC_RESET, 32'h0000_3000, D_pc value after reset and after flush
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- en  input  1  load enable; 0 = stall, register holds
- flush  input  1  replace D contents with a bubble
- F_instr  input  32  instruction fetched this cycle
- F_pc  input  32  PC of F_instr
- D_instr  output  32  registered instruction
- D_pc  output  32  registered PC
- D_pc8  output  32  D_pc + 8, the jal link value
- D_opcode  output  6  D_instr[31:26]
- D_rs / D_rt / D_rd  output  5 each  D_instr[25:21] / [20:16] / [15:11]
- D_funct  output  6  D_instr[5:0]
- D_imm16  output  16  D_instr[15:0], drives the extender imm input
- D_extOp  output  1  extender mode: 0 = zero-extend, 1 = sign-extend
- D_valid  output  1  1 = D holds a real instruction, 0 = bubble
- stall_cnt  output  16  saturating count of stall cycles since reset

## Operation
- Priority on every rising edge: reset_n==0 > flush==1 > en==0 > load.
- Reset and flush: D_instr = 0 (sll $0,$0,0 nop), D_pc = PC_RESET, D_extOp = 0, D_valid = 0.
- Stall (en==0, flush==0): all D registers hold their values.
- Load (en==1, flush==0): D_instr <= F_instr, D_pc <= F_pc, D_valid <= 1, D_extOp <= decode(F_instr[31:26]).
- decode is computed from F_instr before the flop, so D_extOp settles at the same time as D_instr:
  - opcodes 6'h0C andi, 6'h0D ori, 6'h0E xori and 6'h0F lui -> 0
  - every other opcode (lw, sw, beq, bne, addi, addiu, slti, R-type, j, jal, ...) -> 1
  - R-type and jump D_extOp values are don't-care downstream but must still follow this rule.
- D_pc8 = D_pc + 32'd8, modulo 2^32. 32'hFFFF_FFFC yields 32'h0000_0004.
- All field outputs are continuous slices of D_instr and carry no extra register.
- stall_cnt:
  - Cleared to 0 by reset only; flush does not clear it.
  - Increments by 1 on each edge with en==0 and flush==0.
  - Saturates at 16'hFFFF.

## Timing
- Latency is 1 cycle. F_instr present before edge N appears on D_instr after edge N.
- Stall of k cycles holds D for exactly k edges. The value loaded on the next en==1 edge is the F_instr present at that edge, since the PC register is stalled upstream in the same cycle.
- flush and en==0 in the same cycle produce a bubble; stall_cnt does not increment.
- Reset taken mid-stall or mid-flush overrides both. stall_cnt = 0 on the following cycle.
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset_n=0 for 2 cycles, then release -> D_instr=0, D_pc=32'h0000_3000, D_pc8=32'h0000_3008, D_valid=0, D_extOp=0, stall_cnt=0.
- Load ori $t0,$zero,0x8001 (F_instr=32'h3408_8001, F_pc=32'h3000), en=1 -> next cycle D_imm16=16'h8001, D_extOp=0, D_rt=8, D_valid=1. Then load lw $t1,-4($sp) (32'h8FA9_FFFC) -> D_extOp=1, D_imm16=16'hFFFC, D_rs=29.
- Stall: load 32'h1109_0003 (beq) at PC 32'h3004, then hold en=0 for 3 cycles while F_instr changes -> D holds beq and PC 32'h3004, stall_cnt=3. With en=1 again, the next edge loads the current F_instr.
- Flush with simultaneous stall: D holds a valid instruction, assert flush=1 and en=0 together -> D_instr=0, D_valid=0, D_pc=PC_RESET, stall_cnt unchanged.
- Wrap: F_pc=32'hFFFF_FFFC -> D_pc8=32'h0000_0004. lui (32'h3C01_1234) -> D_extOp=0.
- Saturation: hold en=0 for 65540 cycles -> stall_cnt stays at 16'hFFFF. Assert reset_n=0 for one cycle -> stall_cnt=0.
